// File: rtl/des3_arbiter.sv
// -----------------------------------------------------------------------------
// des3_arbiter
// Round-robin front end that shares one 3DES core between two requesters.
// One block is in flight at a time: IDLE -> LOAD -> ISSUE -> BUSY -> RESP.
// A watchdog in BUSY turns a hung core into an error response.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o    request handshake (ready is a 1-cycle accept)
//   reqN_data_i                    64-bit plaintext block
//   reqN_key_i                     {key0,key1,key2}, key0 in [191:128]
//   rsp_valid_o / rsp_ready_i      response handshake, held until taken
//   rsp_id_o, rsp_data_o, rsp_err_o  owner, ciphertext, timeout flag
//   core_select_o                  1-cycle start pulse to the core
//   core_key0/1/2_o, core_data_o   operands to the core
//   core_out_i, core_done_i        core result and completion strobe
// -----------------------------------------------------------------------------
module des3_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [63:0]  req0_data_i,
    input  logic [191:0] req0_key_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [63:0]  req1_data_i,
    input  logic [191:0] req1_key_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_id_o,
    output logic [63:0]  rsp_data_o,
    output logic         rsp_err_o,
    output logic         core_select_o,
    output logic [63:0]  core_key0_o,
    output logic [63:0]  core_key1_o,
    output logic [63:0]  core_key2_o,
    output logic [63:0]  core_data_o,
    input  logic [63:0]  core_out_i,
    input  logic         core_done_i
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, BUSY, RESP} state_e;

    state_e         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;
    logic [191:0]   key_q, key_d;
    logic [63:0]    data_q, data_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [63:0]    rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;
    logic           win;
    logic           rdy0, rdy1;

    assign cnt_inc = cnt_q + CW'(1);

    // Tie goes to the requester that was not granted last; otherwise the
    // only valid requester wins.
    assign win = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        data_d       = data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        rdy0         = 1'b0;
        rdy1         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    rdy0         = ~win;
                    rdy1         = win;
                    last_grant_d = win;
                    key_d        = win ? req1_key_i  : req0_key_i;
                    data_d       = win ? req1_data_i : req0_data_i;
                    state_d      = LOAD;
                end
            end
            // Operands are already on the core pins; give its key register a
            // cycle to capture them before the start pulse.
            LOAD:  state_d = ISSUE;
            ISSUE: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                // Completion beats the watchdog when both land together.
                if (core_done_i) begin
                    rsp_data_d  = core_out_i;
                    rsp_id_d    = last_grant_q;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT)) begin
                        rsp_data_d  = '0;
                        rsp_id_d    = last_grant_q;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            key_q        <= '0;
            data_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            data_q       <= data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // The accept strobe is combinational from IDLE; masking with reset keeps
    // it low while reset is held even if a requester is already valid.
    assign req0_ready_o  = rdy0 & rst_ni;
    assign req1_ready_o  = rdy1 & rst_ni;
    assign core_select_o = (state_q == ISSUE);
    assign core_key0_o   = key_q[191:128];
    assign core_key1_o   = key_q[127:64];
    assign core_key2_o   = key_q[63:0];
    assign core_data_o   = data_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_err_o     = rsp_err_q;

endmodule
